// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer.
package md_pkg;

    localparam int unsigned XLEN = 32;

    // EX-stage command encodings; 6 and 7 are reserved and ignored
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2
    } md_state_e;

    // MULT/MULTU/DIV/DIVU occupy the unit; MTHI/MTLO do not
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    // Even arithmetic encodings are the signed variants
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op[0] == 1'b0);
    endfunction

endpackage

// File: rtl/md_core.sv
// Operand capture and combinational product / quotient / remainder.
module md_core
    import md_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic              is_signed,
    input  logic [XLEN-1:0]   rs_val,
    input  logic [XLEN-1:0]   rt_val,
    output logic [2*XLEN-1:0] product,
    output logic [XLEN-1:0]   quotient,
    output logic [XLEN-1:0]   remainder,
    output logic              div_by_zero
);

    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic            sgn_q, sgn_d;

    logic [2*XLEN-1:0] a_ext, b_ext;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag;

    // Hold operands until the next accepted command
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        sgn_d = sgn_q;
        if (capture) begin
            a_d   = rs_val;
            b_d   = rt_val;
            sgn_d = is_signed;
        end
    end

    // Operand registers, cleared by synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            sgn_q <= sgn_d;
        end
    end

    // Sign-magnitude divide so signed results truncate toward zero
    always_comb begin
        a_ext       = {{XLEN{sgn_q & a_q[XLEN-1]}}, a_q};
        b_ext       = {{XLEN{sgn_q & b_q[XLEN-1]}}, b_q};
        product     = a_ext * b_ext;
        a_neg       = sgn_q & a_q[XLEN-1];
        b_neg       = sgn_q & b_q[XLEN-1];
        a_mag       = a_neg ? XLEN'(-a_q) : a_q;
        b_mag       = b_neg ? XLEN'(-b_q) : b_q;
        div_by_zero = (b_q == '0);
        b_safe      = div_by_zero ? XLEN'(1) : b_mag;
        q_mag       = a_mag / b_safe;
        r_mag       = a_mag % b_safe;
        quotient    = (a_neg ^ b_neg) ? XLEN'(-q_mag) : q_mag;
        remainder   = a_neg ? XLEN'(-r_mag) : r_mag;
    end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer: latency counter, ID-stage stall and HI/LO registers.
module md_sched
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            md_use_d,
    output logic            busy,
    output logic            stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             core_capture;

    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient, remainder;
    logic              div_by_zero;

    md_core u_core (
        .clk         (clk),
        .reset       (reset),
        .capture     (core_capture),
        .is_signed   (is_signed_op(op)),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .product     (product),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Next-state: accept commands in IDLE, count down, commit at zero
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        core_capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            core_capture = 1'b1;
                            cnt_d        = CNT_W'(MULT_CYCLES - 1);
                            state_d      = ST_MUL_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            core_capture = 1'b1;
                            cnt_d        = CNT_W'(DIV_CYCLES - 1);
                            state_d      = ST_DIV_RUN;
                        end
                        MD_MTHI: hi_d = rs_val;
                        MD_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            ST_MUL_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    {hi_d, lo_d} = product;
                    state_d      = ST_IDLE;
                end
            end
            ST_DIV_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // A zero divisor leaves HI/LO untouched
                    if (!div_by_zero) begin
                        lo_d = quotient;
                        hi_d = remainder;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, counter and HI/LO registers; reset discards any in-flight op
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy  = busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    // Stall covers the start cycle itself, so it cannot wait for busy
    assign stall = md_use_d & (busy_q | (start & is_arith_op(op)));

endmodule
